// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount accumulator.
package popcount_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Bits needed to represent a count of 0..n.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcount_accum_tree.sv
// Combinational population count of an N-bit vector; module name popcount_tree.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter  int N  = 16,
  localparam int CW = count_w(N)
) (
  input  logic [N-1:0]  data,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/popcount_accum.sv
// Multi-beat saturating popcount accumulator with threshold fire flag.
// Define POPCOUNT_APPROX_EN to ignore the low APPROX_DROP input bits when counting.
//
// state | meaning
// ACCUM | accepting beats, summing popcounts into acc
// HOLD  | result presented on out_valid, waiting for out_ready
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int          N           = 16,
  parameter int          ACC_W       = 8,
  parameter int unsigned THRESH      = 20,
  parameter int          APPROX_DROP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_fire,
  output logic             out_sat
);

  localparam int CW = count_w(N);

`ifdef POPCOUNT_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  localparam int          DROP = APPROX_EN ? APPROX_DROP : 0;
  localparam logic [N-1:0] MASK = ~((N'(1) << DROP) - N'(1));

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             sat_flag;

  logic [N-1:0]     masked;
  logic [CW-1:0]    pc;
  logic [ACC_W:0]   sum_full;
  logic             overflow;
  logic [ACC_W-1:0] sum_sat;
  logic             accept;

  assign masked = in_data & MASK;

  popcount_tree #(.N(N)) u_tree (
    .data  (masked),
    .count (pc)
  );

  // One extra bit is enough: acc and pc are each below 2^ACC_W.
  assign sum_full = {1'b0, acc} + (ACC_W + 1)'(pc);
  assign overflow = sum_full[ACC_W];
  assign sum_sat  = overflow ? '1 : sum_full[ACC_W-1:0];

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign out_fire  = (32'(out_sum) >= 32'(THRESH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      sat_flag <= 1'b0;
      out_sum  <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (in_last) begin
              out_sum  <= sum_sat;
              out_sat  <= sat_flag | overflow;
              acc      <= '0;
              sat_flag <= 1'b0;
              state    <= HOLD;
            end else begin
              acc      <= sum_sat;
              sat_flag <= sat_flag | overflow;
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Self-checking bench for popcount_accum against a count-and-clamp reference model.
module tb_popcount_accum;

  localparam int N      = 16;
  localparam int ACC_W  = 8;
  localparam int THRESH = 20;
  localparam int MAXV   = 255;

`ifdef POPCOUNT_APPROX_EN
  localparam logic [N-1:0] TB_MASK = 16'hFFFC;
`else
  localparam logic [N-1:0] TB_MASK = 16'hFFFF;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_fire;
  logic             out_sat;

  int n_cmp = 0;
  int n_err = 0;

  popcount_accum #(.N(N), .ACC_W(ACC_W), .THRESH(THRESH), .APPROX_DROP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_fire  (out_fire),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  function automatic int pc_model(input logic [N-1:0] d);
    return $countones(d & TB_MASK);
  endfunction

  // Expected {out_valid, out_sum, out_fire, out_sat} for a neuron whose raw popcount total is t.
  function automatic logic [ACC_W+2:0] exp_result(input int t);
    int s;
    s = (t > MAXV) ? MAXV : t;
    return {1'b1, ACC_W'(s), (s >= THRESH), (t > MAXV)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [N-1:0] d, input logic last);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    tick();
    in_valid = 1'b0;
    in_data  = $urandom();
    in_last  = $urandom_range(0, 1);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, out_sum, out_fire, out_sat} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: rdy=%0b vld=%0b sum=%0d fire=%0b sat=%0b, required rdy=1 vld=0 sum=0 fire=0 sat=0",
               in_ready, out_valid, out_sum, out_fire, out_sat);
    end
  endtask

  task automatic test_directed();
    logic [ACC_W+2:0] e;
    // single full beat, result exactly one cycle after acceptance
    send_beat(16'hFFFF, 1'b1);
    e = exp_result(pc_model(16'hFFFF));
    n_cmp++;
    if ({out_valid, out_sum, out_fire, out_sat} !== e) begin
      n_err++;
      $display("FAIL single_ffff: vld/sum/fire/sat=%0b/%0d/%0b/%0b, required %0b/%0d/%0b/%0b",
               out_valid, out_sum, out_fire, out_sat, e[ACC_W+2], e[ACC_W+1:2], e[1], e[0]);
    end
    take_result();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL release_single: rdy=%0b vld=%0b, required rdy=1 vld=0", in_ready, out_valid);
    end

    send_beat(16'h00FF, 1'b0);
    send_beat(16'h0F0F, 1'b0);
    send_beat(16'hFFFF, 1'b1);
    e = exp_result(pc_model(16'h00FF) + pc_model(16'h0F0F) + pc_model(16'hFFFF));
    n_cmp++;
    if ({out_valid, out_sum, out_fire, out_sat} !== e) begin
      n_err++;
      $display("FAIL three_beat: vld/sum/fire/sat=%0b/%0d/%0b/%0b, required %0b/%0d/%0b/%0b",
               out_valid, out_sum, out_fire, out_sat, e[ACC_W+2], e[ACC_W+1:2], e[1], e[0]);
    end
    take_result();

    send_beat(16'h0003, 1'b1);
    e = exp_result(pc_model(16'h0003));
    n_cmp++;
    if ({out_valid, out_sum, out_fire, out_sat} !== e) begin
      n_err++;
      $display("FAIL low_bits_0003: vld/sum/fire/sat=%0b/%0d/%0b/%0b, required %0b/%0d/%0b/%0b",
               out_valid, out_sum, out_fire, out_sat, e[ACC_W+2], e[ACC_W+1:2], e[1], e[0]);
    end
    take_result();
  endtask

  task automatic test_saturation();
    logic [ACC_W+2:0] e;
    int total;
    total = 0;
    for (int i = 0; i < 17; i++) begin
      send_beat(16'hFFFF, i == 16);
      total += pc_model(16'hFFFF);
    end
    e = exp_result(total);
    n_cmp++;
    if ({out_valid, out_sum, out_fire, out_sat} !== e) begin
      n_err++;
      $display("FAIL saturate_17: vld/sum/fire/sat=%0b/%0d/%0b/%0b, required %0b/%0d/%0b/%0b",
               out_valid, out_sum, out_fire, out_sat, e[ACC_W+2], e[ACC_W+1:2], e[1], e[0]);
    end
    take_result();

    // saturation flag must not leak into the next neuron
    send_beat(16'h0001, 1'b1);
    e = exp_result(pc_model(16'h0001));
    n_cmp++;
    if ({out_valid, out_sum, out_fire, out_sat} !== e) begin
      n_err++;
      $display("FAIL after_sat: vld/sum/fire/sat=%0b/%0d/%0b/%0b, required %0b/%0d/%0b/%0b",
               out_valid, out_sum, out_fire, out_sat, e[ACC_W+2], e[ACC_W+1:2], e[1], e[0]);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    logic [ACC_W+2:0] e;
    send_beat(16'h7777, 1'b0);
    send_beat(16'h1234, 1'b1);
    e = exp_result(pc_model(16'h7777) + pc_model(16'h1234));
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({in_ready, out_valid, out_sum, out_fire, out_sat} !== {1'b0, e}) begin
        n_err++;
        $display("FAIL hold_cycle%0d: rdy=%0b vld/sum/fire/sat=%0b/%0d/%0b/%0b, required rdy=0 %0b/%0d/%0b/%0b",
                 c, in_ready, out_valid, out_sum, out_fire, out_sat, e[ACC_W+2], e[ACC_W+1:2], e[1], e[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL hold_release: rdy=%0b vld=%0b, required rdy=1 vld=0", in_ready, out_valid);
    end
    // beat held high during HOLD is only now consumed
    tick();
    in_valid = 1'b0;
    e = exp_result(pc_model(16'hAAAA));
    n_cmp++;
    if ({out_valid, out_sum, out_fire, out_sat} !== e) begin
      n_err++;
      $display("FAIL held_beat: vld/sum/fire/sat=%0b/%0d/%0b/%0b, required %0b/%0d/%0b/%0b",
               out_valid, out_sum, out_fire, out_sat, e[ACC_W+2], e[ACC_W+1:2], e[1], e[0]);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    logic [ACC_W+2:0] e;
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_mid_state: rdy=%0b vld=%0b, required rdy=1 vld=0", in_ready, out_valid);
    end
    send_beat(16'h0F0F, 1'b1);
    e = exp_result(pc_model(16'h0F0F));
    n_cmp++;
    if ({out_valid, out_sum, out_fire, out_sat} !== e) begin
      n_err++;
      $display("FAIL rst_mid_sum: vld/sum/fire/sat=%0b/%0d/%0b/%0b, required %0b/%0d/%0b/%0b",
               out_valid, out_sum, out_fire, out_sat, e[ACC_W+2], e[ACC_W+1:2], e[1], e[0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, out_sum, out_sat} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_hold: rdy=%0b vld=%0b sum=%0d sat=%0b, required rdy=1 vld=0 sum=0 sat=0",
               in_ready, out_valid, out_sum, out_sat);
    end
  endtask

  task automatic test_random();
    logic [ACC_W+2:0] e;
    logic [N-1:0]     d;
    int               len;
    int               total;
    for (int k = 0; k < 40; k++) begin
      len   = $urandom_range(1, 20);
      total = 0;
      for (int b = 0; b < len; b++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          in_valid = 1'b0;
          in_data  = $urandom();
          in_last  = 1'b1;
          tick();
        end
        d = $urandom();
        total += pc_model(d);
        send_beat(d, b == len - 1);
      end
      e = exp_result(total);
      n_cmp++;
      if ({out_valid, out_sum, out_fire, out_sat} !== e) begin
        n_err++;
        $display("FAIL random_n%0d: len=%0d vld/sum/fire/sat=%0b/%0d/%0b/%0b, required %0b/%0d/%0b/%0b",
                 k, len, out_valid, out_sum, out_fire, out_sat, e[ACC_W+2], e[ACC_W+1:2], e[1], e[0]);
      end
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        tick();
        n_cmp++;
        if ({in_ready, out_valid, out_sum, out_fire, out_sat} !== {1'b0, e}) begin
          n_err++;
          $display("FAIL random_hold_n%0d: rdy=%0b sum=%0d, required rdy=0 sum=%0d",
                   k, in_ready, out_sum, e[ACC_W+1:2]);
        end
      end
      take_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 SHALL have parameter N, default 16, input vector width per beat (2..64).
REQ-002 SHALL have parameter ACC_W, default 8, accumulator and result width (>= clog2(N+1)).
REQ-003 SHALL have parameter THRESH, default 20, activation threshold compared against the result.
REQ-004 SHALL have parameter APPROX_DROP, default 2, number of LSB input bits ignored in approximate mode (0..N-1).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  block accepts beat.
REQ-009 SHALL have port in_data  input  N  bit vector to be counted.
REQ-010 SHALL have port in_last  input  1  final beat of current neuron.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_sum  output  ACC_W  accumulated popcount.
REQ-014 SHALL have port out_fire  output  1  out_sum >= THRESH.
REQ-015 SHALL have port out_sat  output  1  accumulation saturated.

Function
REQ-016 SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 SHALL accept a beat when in_valid && in_ready; per-beat count pc = popcount(in_data & mask), mask all-ones in exact mode.
REQ-018 SHALL in ACCUM on accepted non-last beat: acc <= sat(acc + pc), sat_flag |= overflow.
REQ-019 SHALL in ACCUM on accepted last beat: out_sum <= sat(acc + pc), out_sat <= sat_flag | overflow, acc <= 0, sat_flag <= 0, go HOLD.
REQ-020 SHALL present the result on out_valid exactly one cycle after the last beat is accepted.
REQ-021 SHALL saturate at 2^ACC_W-1; never wrap.
REQ-022 SHALL hold out_sum, out_fire, out_sat stable while out_valid && !out_ready.
REQ-023 SHALL return to ACCUM on out_valid && out_ready; first new beat accepted no earlier than the following cycle (no same-cycle bypass).
REQ-024 SHALL compute out_fire combinationally from registered out_sum with unsigned compare.
REQ-025 SHALL ignore in_data, in_last when in_valid=0; in_valid held in HOLD is not consumed.
REQ-026 SHALL treat a single-beat neuron (in_last on first beat) as out_sum = pc.

Reset
REQ-027 SHALL on rst: state=ACCUM, acc=0, sat_flag=0, out_sum=0, out_sat=0, out_valid=0, in_ready=1 the next cycle.
REQ-028 SHALL on rst mid-accumulation or in HOLD discard partial sums and pending results.

Configuration
REQ-029 SHALL, when POPCOUNT_APPROX_EN is defined, zero the low APPROX_DROP bits of in_data before counting (mask = ~((1<<APPROX_DROP)-1)).
REQ-030 SHALL, when POPCOUNT_APPROX_EN is undefined, count all N bits and ignore APPROX_DROP.

Structure
REQ-031 SHALL place the FSM state enum and a clog2-based count-width function in shared package popcount_pkg.
REQ-032 SHALL instantiate combinational sub-module popcount_tree (parameter N, output clog2(N+1) bits) for per-beat counting.

Verification
REQ-033 SHALL cover single beat 0xFFFF, last=1 -> out_sum=16, out_fire=0, out_sat=0, out_valid one cycle later.
REQ-034 SHALL cover beats 0x00FF, 0x0F0F, 0xFFFF(last) -> out_sum=32, out_fire=1.
REQ-035 SHALL cover 17 beats of 0xFFFF with ACC_W=8 -> out_sum=255, out_sat=1.
REQ-036 SHALL cover out_ready held low 5 cycles -> in_ready=0, outputs stable; then out_ready=1 -> ACCUM next cycle.
REQ-037 SHALL cover POPCOUNT_APPROX_EN defined, beat 0x0003 last -> out_sum=0; undefined -> out_sum=2.
REQ-038 SHALL cover rst asserted after 2 accepted beats -> out_valid=0, next neuron sums from zero.
